// File: rtl/ysyx_24110006_axi_pkg.sv
// Shared AXI encodings and read-slave FSM states for the ysyx_24110006 AXI blocks.
// WRAP legality is consumed by the top only when YSYX_24110006_RSLAVE_WRAP_EN is defined.
package ysyx_24110006_axi_pkg;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam logic [2:0] SIZE_4B     = 3'b010;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DELAY = 2'd1,
        ST_FETCH = 2'd2,
        ST_RESP  = 2'd3
    } rslave_state_e;

    // A WRAP burst must cover a power-of-two window of 2, 4, 8 or 16 beats.
    function automatic logic wrap_len_legal(input logic [7:0] len);
        return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
    endfunction

endpackage

// File: rtl/ysyx_24110006_rslave_mem.sv
// DEPTH_WORDS x 32 synchronous-read storage for the AXI read slave; contents are
// preloaded hierarchically through the mem array and never cleared by reset.
module ysyx_24110006_rslave_mem #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned AW          = 10
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          rd_en,
    input  logic          rd_zero,
    input  logic [AW-1:0] rd_addr,
    output logic [31:0]   rd_data
);

    logic [31:0] mem [DEPTH_WORDS];

    // The output register doubles as the response data register, so error beats zero it here.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= rd_zero ? '0 : mem[rd_addr];
        end
    end

endmodule

// File: rtl/ysyx_24110006_axi_rslave.sv
// AXI4 read-channel responder: one outstanding burst, FIXED/INCR bursts, optional WRAP
// support when YSYX_24110006_RSLAVE_WRAP_EN is defined.
module ysyx_24110006_axi_rslave
    import ysyx_24110006_axi_pkg::*;
#(
    parameter logic [31:0] ADDR_BASE   = 32'h3000_0000,
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned LATENCY     = 2
) (
    input  logic        i_clock,
    input  logic        i_reset,
    input  logic [31:0] i_axi_araddr,
    input  logic        i_axi_arvalid,
    output logic        o_axi_arready,
    input  logic [3:0]  i_axi_arid,
    input  logic [7:0]  i_axi_arlen,
    input  logic [2:0]  i_axi_arsize,
    input  logic [1:0]  i_axi_arburst,
    output logic [31:0] o_axi_rdata,
    output logic        o_axi_rvalid,
    input  logic        i_axi_rready,
    output logic [1:0]  o_axi_rresp,
    output logic [3:0]  o_axi_rid,
    output logic        o_axi_rlast
);

    localparam int unsigned AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    rslave_state_e state;
    logic [31:0]   addr;
    logic [3:0]    id;
    logic [7:0]    len;
    logic [2:0]    size;
    logic [1:0]    burst;
    logic [7:0]    beat_cnt;
    logic [3:0]    delay_cnt;
    logic          arready;
    logic          rvalid;
    logic          rlast;
    logic [1:0]    rresp;
    logic [3:0]    rid;

    logic [31:0]   word_off;
    logic [31:0]   word_idx;
    logic [31:0]   wrap_mask;
    logic [31:0]   next_addr;
    logic          in_range;
    logic          wrap_ok;
    logic          fmt_ok;
    logic [1:0]    beat_resp;

    always_comb begin
        word_off  = addr - ADDR_BASE;
        word_idx  = word_off >> 2;
        in_range  = word_idx < 32'(DEPTH_WORDS);
`ifdef YSYX_24110006_RSLAVE_WRAP_EN
        wrap_ok   = wrap_len_legal(len);
`else
        wrap_ok   = 1'b0;
`endif
        case (burst)
            BURST_FIXED, BURST_INCR: fmt_ok = (size == SIZE_4B);
            BURST_WRAP:              fmt_ok = (size == SIZE_4B) && wrap_ok;
            default:                 fmt_ok = 1'b0;
        endcase
        // A malformed burst reports SLVERR even where the address would also decode badly.
        if (!fmt_ok) begin
            beat_resp = RESP_SLVERR;
        end else if (!in_range) begin
            beat_resp = RESP_DECERR;
        end else begin
            beat_resp = RESP_OKAY;
        end
        wrap_mask = {22'b0, len, 2'b11};
        case (burst)
            BURST_INCR: next_addr = addr + 32'd4;
            BURST_WRAP: next_addr = (addr & ~wrap_mask) | ((addr + 32'd4) & wrap_mask);
            default:    next_addr = addr;
        endcase
    end

    ysyx_24110006_rslave_mem #(
        .DEPTH_WORDS(DEPTH_WORDS),
        .AW         (AW)
    ) u_mem (
        .clk    (i_clock),
        .rst_n  (i_reset),
        .rd_en  (state == ST_FETCH),
        .rd_zero(beat_resp != RESP_OKAY),
        .rd_addr(word_idx[AW-1:0]),
        .rd_data(o_axi_rdata)
    );

    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            state     <= ST_IDLE;
            arready   <= 1'b0;
            rvalid    <= 1'b0;
            rlast     <= 1'b0;
            rresp     <= RESP_OKAY;
            rid       <= '0;
            addr      <= '0;
            id        <= '0;
            len       <= '0;
            size      <= '0;
            burst     <= '0;
            beat_cnt  <= '0;
            delay_cnt <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (arready && i_axi_arvalid) begin
                        addr      <= i_axi_araddr;
                        id        <= i_axi_arid;
                        len       <= i_axi_arlen;
                        size      <= i_axi_arsize;
                        burst     <= i_axi_arburst;
                        beat_cnt  <= '0;
                        delay_cnt <= '0;
                        arready   <= 1'b0;
                        state     <= (LATENCY == 0) ? ST_FETCH : ST_DELAY;
                    end else begin
                        arready   <= 1'b1;
                    end
                end
                ST_DELAY: begin
                    if (delay_cnt == 4'(LATENCY - 1)) begin
                        state     <= ST_FETCH;
                    end else begin
                        delay_cnt <= delay_cnt + 4'd1;
                    end
                end
                ST_FETCH: begin
                    state  <= ST_RESP;
                    rvalid <= 1'b1;
                    rresp  <= beat_resp;
                    rlast  <= (beat_cnt == len);
                    rid    <= id;
                end
                ST_RESP: begin
                    if (i_axi_rready) begin
                        rvalid <= 1'b0;
                        if (rlast) begin
                            state   <= ST_IDLE;
                            arready <= 1'b1;
                        end else begin
                            state    <= ST_FETCH;
                            beat_cnt <= beat_cnt + 8'd1;
                            addr     <= next_addr;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign o_axi_arready = arready;
    assign o_axi_rvalid  = rvalid;
    assign o_axi_rresp   = rresp;
    assign o_axi_rid     = rid;
    assign o_axi_rlast   = rlast;

endmodule

// File: tb/tb_ysyx_24110006_axi_rslave.sv
// Directed bench for ysyx_24110006_axi_rslave; WRAP expectations follow
// YSYX_24110006_RSLAVE_WRAP_EN.
module tb_ysyx_24110006_axi_rslave;

    localparam logic [31:0] BASE = 32'h3000_0000;
    localparam int unsigned DEPTH = 1024;
    localparam int unsigned LAT = 2;

    logic        i_clock = 1'b0;
    logic        i_reset = 1'b0;
    logic [31:0] i_axi_araddr = '0;
    logic        i_axi_arvalid = 1'b0;
    logic        o_axi_arready;
    logic [3:0]  i_axi_arid = '0;
    logic [7:0]  i_axi_arlen = '0;
    logic [2:0]  i_axi_arsize = 3'b010;
    logic [1:0]  i_axi_arburst = 2'b01;
    logic [31:0] o_axi_rdata;
    logic        o_axi_rvalid;
    logic        i_axi_rready = 1'b1;
    logic [1:0]  o_axi_rresp;
    logic [3:0]  o_axi_rid;
    logic        o_axi_rlast;

    int n_checks = 0;
    int n_fail = 0;

    logic [31:0] b_data [16];
    logic [1:0]  b_resp [16];
    logic [3:0]  b_id   [16];
    logic        b_last [16];
    int          b_cyc  [16];

    ysyx_24110006_axi_rslave #(
        .ADDR_BASE  (BASE),
        .DEPTH_WORDS(DEPTH),
        .LATENCY    (LAT)
    ) dut (
        .i_clock      (i_clock),
        .i_reset      (i_reset),
        .i_axi_araddr (i_axi_araddr),
        .i_axi_arvalid(i_axi_arvalid),
        .o_axi_arready(o_axi_arready),
        .i_axi_arid   (i_axi_arid),
        .i_axi_arlen  (i_axi_arlen),
        .i_axi_arsize (i_axi_arsize),
        .i_axi_arburst(i_axi_arburst),
        .o_axi_rdata  (o_axi_rdata),
        .o_axi_rvalid (o_axi_rvalid),
        .i_axi_rready (i_axi_rready),
        .o_axi_rresp  (o_axi_rresp),
        .o_axi_rid    (o_axi_rid),
        .o_axi_rlast  (o_axi_rlast)
    );

    always #5 i_clock = ~i_clock;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Inputs change and outputs are sampled on the falling edge.
    task automatic do_ar(input logic [31:0] a, input logic [7:0] l, input logic [2:0] s,
                         input logic [1:0] b, input logic [3:0] id);
        int n;
        n = 0;
        i_axi_araddr  = a;
        i_axi_arlen   = l;
        i_axi_arsize  = s;
        i_axi_arburst = b;
        i_axi_arid    = id;
        i_axi_arvalid = 1'b1;
        while (!o_axi_arready && n < 50) begin
            @(posedge i_clock); @(negedge i_clock); n++;
        end
        n_checks++;
        if (o_axi_arready !== 1'b1) begin
            n_fail++;
            $display("FAIL ar_timeout: arready=%b required 1", o_axi_arready);
        end
        @(posedge i_clock); @(negedge i_clock);
        i_axi_arvalid = 1'b0;
    endtask

    task automatic get_beat(input int i, input int stall);
        int cyc;
        cyc = 0;
        i_axi_rready = (stall == 0);
        while (!o_axi_rvalid && cyc < 200) begin
            @(posedge i_clock); @(negedge i_clock); cyc++;
        end
        n_checks++;
        if (o_axi_rvalid !== 1'b1) begin
            n_fail++;
            $display("FAIL rvalid_timeout beat %0d: rvalid=%b required 1", i, o_axi_rvalid);
        end
        b_data[i] = o_axi_rdata;
        b_resp[i] = o_axi_rresp;
        b_id[i]   = o_axi_rid;
        b_last[i] = o_axi_rlast;
        b_cyc[i]  = cyc + 1;
        for (int k = 0; k < stall; k++) begin
            @(posedge i_clock); @(negedge i_clock);
            n_checks++;
            if (o_axi_rvalid !== 1'b1 || o_axi_rdata !== b_data[i] || o_axi_rresp !== b_resp[i]
                || o_axi_rlast !== b_last[i] || o_axi_rid !== b_id[i]) begin
                n_fail++;
                $display("FAIL hold_stable beat %0d: rvalid=%b rdata=%h required rvalid=1 rdata=%h",
                         i, o_axi_rvalid, o_axi_rdata, b_data[i]);
            end
            n_checks++;
            if (o_axi_arready !== 1'b0) begin
                n_fail++;
                $display("FAIL ar_ignored: arready=%b required 0", o_axi_arready);
            end
        end
        i_axi_rready = 1'b1;
        @(posedge i_clock); @(negedge i_clock);
    endtask

    task automatic run_burst(input logic [31:0] a, input logic [7:0] l, input logic [2:0] s,
                             input logic [1:0] b, input logic [3:0] id);
        do_ar(a, l, s, b, id);
        for (int i = 0; i <= int'(l); i++) get_beat(i, 0);
    endtask

    task automatic test_reset();
        repeat (3) @(posedge i_clock);
        @(negedge i_clock);
        n_checks++;
        if (o_axi_arready !== 1'b0 || o_axi_rvalid !== 1'b0 || o_axi_rlast !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: arready=%b rvalid=%b rlast=%b required 0 0 0",
                     o_axi_arready, o_axi_rvalid, o_axi_rlast);
        end
        n_checks++;
        if (o_axi_rdata !== 32'h0 || o_axi_rresp !== 2'b00 || o_axi_rid !== 4'h0) begin
            n_fail++;
            $display("FAIL reset_data: rdata=%h rresp=%b rid=%h required 0 0 0",
                     o_axi_rdata, o_axi_rresp, o_axi_rid);
        end
        i_reset = 1'b1;
        @(posedge i_clock); @(negedge i_clock);
        n_checks++;
        if (o_axi_arready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_release_arready: got %b required 1", o_axi_arready);
        end
    endtask

    task automatic test_incr_burst();
        logic [31:0] exp_d [4] = '{32'hA0, 32'hA1, 32'hA2, 32'hA3};
        run_burst(32'h3000_0000, 8'd3, 3'b010, 2'b01, 4'd5);
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (b_data[i] !== exp_d[i] || b_resp[i] !== 2'b00) begin
                n_fail++;
                $display("FAIL incr_beat[%0d]: rdata=%h rresp=%b required %h 00", i, b_data[i], b_resp[i], exp_d[i]);
            end
            n_checks++;
            if (b_id[i] !== 4'd5 || b_last[i] !== (i == 3)) begin
                n_fail++;
                $display("FAIL incr_id_last[%0d]: rid=%h rlast=%b required 5 %b", i, b_id[i], b_last[i], i == 3);
            end
            n_checks++;
            if (b_cyc[i] != ((i == 0) ? 4 : 2)) begin
                n_fail++;
                $display("FAIL incr_timing[%0d]: %0d cycles required %0d", i, b_cyc[i], (i == 0) ? 4 : 2);
            end
        end
    endtask

    task automatic test_back_pressure();
        logic [31:0] exp_d [4] = '{32'hA0, 32'hA1, 32'hA2, 32'hA3};
        do_ar(32'h3000_0000, 8'd3, 3'b010, 2'b01, 4'd5);
        get_beat(0, 0);
        i_axi_araddr  = 32'h3000_0100;
        i_axi_arid    = 4'hE;
        i_axi_arvalid = 1'b1;
        get_beat(1, 3);
        i_axi_arvalid = 1'b0;
        get_beat(2, 0);
        get_beat(3, 0);
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (b_data[i] !== exp_d[i] || b_last[i] !== (i == 3) || b_id[i] !== 4'd5) begin
                n_fail++;
                $display("FAIL bp_beat[%0d]: rdata=%h rlast=%b rid=%h required %h %b 5",
                         i, b_data[i], b_last[i], b_id[i], exp_d[i], i == 3);
            end
        end
        n_checks++;
        if (o_axi_rvalid !== 1'b0 || o_axi_arready !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_end: rvalid=%b arready=%b required 0 1", o_axi_rvalid, o_axi_arready);
        end
    endtask

    task automatic test_decerr_edge();
        run_burst(32'h3000_0FFC, 8'd1, 3'b010, 2'b01, 4'd2);
        n_checks++;
        if (b_data[0] !== 32'hC0DE_03FF || b_resp[0] !== 2'b00 || b_last[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL edge_beat0: rdata=%h rresp=%b rlast=%b required c0de03ff 00 0", b_data[0], b_resp[0], b_last[0]);
        end
        n_checks++;
        if (b_data[1] !== 32'h0 || b_resp[1] !== 2'b11 || b_last[1] !== 1'b1) begin
            n_fail++;
            $display("FAIL edge_beat1: rdata=%h rresp=%b rlast=%b required 0 11 1", b_data[1], b_resp[1], b_last[1]);
        end
    endtask

    task automatic test_below_base();
        run_burst(32'h2FFF_FFFC, 8'd1, 3'b010, 2'b01, 4'd7);
        n_checks++;
        if (b_data[0] !== 32'h0 || b_resp[0] !== 2'b11) begin
            n_fail++;
            $display("FAIL below_beat0: rdata=%h rresp=%b required 0 11", b_data[0], b_resp[0]);
        end
        n_checks++;
        if (b_data[1] !== 32'hA0 || b_resp[1] !== 2'b00 || b_id[1] !== 4'd7) begin
            n_fail++;
            $display("FAIL below_beat1: rdata=%h rresp=%b rid=%h required a0 00 7", b_data[1], b_resp[1], b_id[1]);
        end
    endtask

    task automatic test_fixed();
        run_burst(32'h3000_0006, 8'd2, 3'b010, 2'b00, 4'd1);
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (b_data[i] !== 32'hA1 || b_resp[i] !== 2'b00 || b_last[i] !== (i == 2)) begin
                n_fail++;
                $display("FAIL fixed_beat[%0d]: rdata=%h rresp=%b rlast=%b required a1 00 %b",
                         i, b_data[i], b_resp[i], b_last[i], i == 2);
            end
        end
    endtask

    task automatic test_bad_size();
        run_burst(32'h3000_0000, 8'd2, 3'b001, 2'b01, 4'd3);
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (b_data[i] !== 32'h0 || b_resp[i] !== 2'b10 || b_last[i] !== (i == 2)) begin
                n_fail++;
                $display("FAIL size_beat[%0d]: rdata=%h rresp=%b rlast=%b required 0 10 %b",
                         i, b_data[i], b_resp[i], b_last[i], i == 2);
            end
        end
    endtask

    task automatic test_wrap();
`ifdef YSYX_24110006_RSLAVE_WRAP_EN
        logic [31:0] exp_d [4] = '{32'hA2, 32'hA3, 32'hA0, 32'hA1};
        logic [1:0]  exp_r = 2'b00;
`else
        logic [31:0] exp_d [4] = '{32'h0, 32'h0, 32'h0, 32'h0};
        logic [1:0]  exp_r = 2'b10;
`endif
        run_burst(32'h3000_0008, 8'd3, 3'b010, 2'b10, 4'd4);
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (b_data[i] !== exp_d[i] || b_resp[i] !== exp_r || b_last[i] !== (i == 3)) begin
                n_fail++;
                $display("FAIL wrap_beat[%0d]: rdata=%h rresp=%b rlast=%b required %h %b %b",
                         i, b_data[i], b_resp[i], b_last[i], exp_d[i], exp_r, i == 3);
            end
        end
    endtask

    task automatic test_burst_reserved();
        run_burst(32'h3000_0000, 8'd1, 3'b010, 2'b11, 4'd6);
        for (int i = 0; i < 2; i++) begin
            n_checks++;
            if (b_data[i] !== 32'h0 || b_resp[i] !== 2'b10 || b_last[i] !== (i == 1)) begin
                n_fail++;
                $display("FAIL rsvd_beat[%0d]: rdata=%h rresp=%b rlast=%b required 0 10 %b",
                         i, b_data[i], b_resp[i], b_last[i], i == 1);
            end
        end
    endtask

    task automatic test_reset_mid_burst();
        int n;
        do_ar(32'h3000_0000, 8'd3, 3'b010, 2'b01, 4'd9);
        get_beat(0, 0);
        get_beat(1, 0);
        i_axi_rready = 1'b0;
        n = 0;
        while (!o_axi_rvalid && n < 50) begin
            @(posedge i_clock); @(negedge i_clock); n++;
        end
        n_checks++;
        if (o_axi_rvalid !== 1'b1 || o_axi_rdata !== 32'hA2) begin
            n_fail++;
            $display("FAIL midrst_beat2: rvalid=%b rdata=%h required 1 a2", o_axi_rvalid, o_axi_rdata);
        end
        i_reset = 1'b0;
        @(posedge i_clock); @(negedge i_clock);
        n_checks++;
        if (o_axi_rvalid !== 1'b0 || o_axi_arready !== 1'b0 || o_axi_rdata !== 32'h0 || o_axi_rid !== 4'h0) begin
            n_fail++;
            $display("FAIL midrst_abort: rvalid=%b arready=%b rdata=%h rid=%h required 0 0 0 0",
                     o_axi_rvalid, o_axi_arready, o_axi_rdata, o_axi_rid);
        end
        i_reset = 1'b1;
        i_axi_rready = 1'b1;
        @(posedge i_clock); @(negedge i_clock);
        n_checks++;
        if (o_axi_arready !== 1'b1 || o_axi_rvalid !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_release: arready=%b rvalid=%b required 1 0", o_axi_arready, o_axi_rvalid);
        end
        run_burst(32'h3000_0004, 8'd1, 3'b010, 2'b01, 4'd3);
        n_checks++;
        if (b_data[0] !== 32'hA1 || b_data[1] !== 32'hA2 || b_last[1] !== 1'b1 || b_id[1] !== 4'd3) begin
            n_fail++;
            $display("FAIL midrst_new_burst: data=%h,%h rlast=%b rid=%h required a1,a2 1 3",
                     b_data[0], b_data[1], b_last[1], b_id[1]);
        end
    endtask

    initial begin
        for (int i = 0; i < 4; i++) dut.u_mem.mem[i] = 32'hA0 + 32'(i);
        dut.u_mem.mem[1023] = 32'hC0DE_03FF;
        test_reset();
        test_incr_burst();
        test_back_pressure();
        test_decerr_edge();
        test_below_base();
        test_fixed();
        test_bad_size();
        test_wrap();
        test_burst_reserved();
        test_reset_mid_burst();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ysyx_24110006_axi_rslave.md
YSYX_24110006_AXI_RSLAVE -- requirements
Module: ysyx_24110006_axi_rslave

Interface
REQ-001 SHALL have parameter ADDR_BASE, default 32'h3000_0000, byte address of word 0.
REQ-002 SHALL have parameter DEPTH_WORDS, default 1024, number of 32-bit words stored.
REQ-003 SHALL have parameter LATENCY, default 2, range 0..15, idle cycles between AR accept and the first memory read.
REQ-004 i_clock  in  1  sole clock, all logic on rising edge.
REQ-005 i_reset  in  1  synchronous, active-low reset.
REQ-006 i_axi_araddr  in  32  read address; i_axi_arvalid in 1; o_axi_arready out 1.
REQ-007 i_axi_arid in 4; i_axi_arlen in 8; i_axi_arsize in 3; i_axi_arburst in 2.
REQ-008 o_axi_rdata out 32; o_axi_rvalid out 1; i_axi_rready in 1; o_axi_rresp out 2; o_axi_rid out 4; o_axi_rlast out 1.

Function
REQ-009 SHALL be an AXI4 read-channel responder, one outstanding burst, no write channels.
REQ-010 FSM states: IDLE, DELAY, FETCH, RESP.
REQ-011 IDLE: arready=1. AR handshake latches addr, id, len, size, burst, then goes to DELAY, or to FETCH when LATENCY=0.
REQ-012 DELAY: counts LATENCY cycles, arready=0, then goes to FETCH.
REQ-013 FETCH: one cycle, issues a synchronous memory read, then goes to RESP.
REQ-014 RESP: rvalid=1. rdata, rresp, rid and rlast SHALL stay stable until rready.
REQ-015 Beat handshake in RESP: non-last beat goes to FETCH; last beat goes to IDLE.
REQ-016 First rvalid SHALL assert LATENCY+2 cycles after the AR handshake edge.
REQ-017 Each later beat's rvalid SHALL assert 2 cycles after the previous beat's handshake.
REQ-018 Beat count = arlen+1. rlast=1 only on beat arlen.
REQ-019 rid SHALL equal the latched arid on every beat.
REQ-020 Word index = (addr-ADDR_BASE)>>2. addr[1:0] is ignored.
REQ-021 INCR (2'b01): addr += 4 per beat, 32-bit wrap-around.
REQ-022 FIXED (2'b00): same addr on every beat.
REQ-023 Beat index outside [0, DEPTH_WORDS): rresp=2'b11 (DECERR), rdata=0. Other beats of the burst are unaffected.
REQ-024 arsize != 3'b010: every beat returns rresp=2'b10 (SLVERR), rdata=0, with full beat count and rlast.
REQ-025 Good beats: rresp=2'b00.
REQ-026 arvalid in any state other than IDLE SHALL be ignored, with arready=0.

Reset
REQ-027 While i_reset=0, on a clock edge: state=IDLE, arready=0, rvalid=0, rlast=0, rresp=0, rid=0, rdata=0, counters=0.
REQ-028 Reset mid-burst SHALL abort the burst with no further beats; memory contents are retained.
REQ-029 arready SHALL rise on the first edge with i_reset=1.

Configuration
REQ-030 Macro YSYX_24110006_RSLAVE_WRAP_EN defined: WRAP (2'b10) is supported.
REQ-031 WRAP with arlen in {1,3,7,15}: wraps within an aligned (arlen+1)*4-byte window.
REQ-032 WRAP with any other arlen returns SLVERR on every beat.
REQ-033 Macro undefined: WRAP and burst 2'b11 return SLVERR on every beat, with full beat count.

Structure
REQ-034 Shared package ysyx_24110006_axi_pkg SHALL hold the BURST_FIXED/INCR/WRAP and RESP_OKAY/SLVERR/DECERR encodings, SIZE_4B=3'b010, and the FSM state encoding.
REQ-035 Sub-module ysyx_24110006_rslave_mem SHALL be a DEPTH_WORDS x 32 synchronous-read memory, preloadable by the bench.

Verification
REQ-036 LATENCY=2, words 0..3 = 0xA0..0xA3; araddr=0x3000_0000, arlen=3, INCR, arid=5, rready=1 -> first rvalid 4 cycles after AR; beats A0,A1,A2,A3; rlast on beat 3; rid=5; OKAY.
REQ-037 Same burst with rready held low 3 cycles on beat 1 -> rdata=0xA1 stable throughout; no beat lost or duplicated.
REQ-038 DEPTH_WORDS=1024; araddr=0x3000_0FFC, arlen=1, INCR -> beat0 OKAY with word 1023, beat1 DECERR with rdata=0.
REQ-039 arsize=3'b001, arlen=2 -> 3 beats, all SLVERR; rlast on beat 2.
REQ-040 WRAP_EN defined: araddr=0x3000_0008, arlen=3, WRAP -> words 2,3,0,1. WRAP_EN undefined: same burst -> 4 beats, all SLVERR.
REQ-041 i_reset=0 during beat 2 of a 4-beat burst -> next edge rvalid=0; arready=1 one cycle after release; a new burst returns correct data.
